video_timing_gen: RTL and testbench



---
 rtl/vip_timing_pkg.sv | 36 +++
 rtl/vip_sync_delay.sv | 31 +++
 rtl/video_timing_gen.sv | 132 +++++++++++++
 tb/tb_video_timing_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vip_timing_pkg.sv
// Shared timing constants, flag payload and polarity helpers for the vip pixel-stream stages.
package vip_timing_pkg;

    // Width of the horizontal/vertical timing counters and pixel coordinates.
    localparam int unsigned CNT_W = 11;

    // Default 480x272 LCD timing.
    localparam int unsigned LCD_H_SYNC  = 41;
    localparam int unsigned LCD_H_BACK  = 2;
    localparam int unsigned LCD_H_DISP  = 480;
    localparam int unsigned LCD_H_FRONT = 2;
    localparam int unsigned LCD_V_SYNC  = 10;
    localparam int unsigned LCD_V_BACK  = 2;
    localparam int unsigned LCD_V_DISP  = 272;
    localparam int unsigned LCD_V_FRONT = 2;

    // Sync polarity encodings: the level a sync pin takes while its pulse is active.
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Stream control flags, polarity-neutral (1 = asserted); all-zero is the idle state.
    typedef struct packed {
        logic frame;
        logic vs;
        logic hs;
        logic de;
    } sync_flags_t;

    localparam int unsigned SYNC_FLAGS_W = $bits(sync_flags_t);

    // Map an asserted/deasserted sync flag onto a pin level for the given polarity.
    function automatic logic sync_level(input logic act, input bit pol);
        return act ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// N-stage register delay for the {frame, vsync, hsync, de} flags; resets to idle.
module vip_sync_delay
    import vip_timing_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SYNC_FLAGS_W-1:0] flags_in,
    output logic [SYNC_FLAGS_W-1:0] flags_out
);

    logic [SYNC_FLAGS_W-1:0] pipe [N];

    // Shift register; stage 0 captures the input, the last stage drives the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= flags_in;
            for (int i = 1; i < N; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign flags_out = pipe[N-1];

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-stream source: frame timing counters, upstream pixel requests and a
// 2-clk aligned sync/de/data output stream.
module video_timing_gen
    import vip_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = LCD_H_SYNC,
    parameter int unsigned H_BACK   = LCD_H_BACK,
    parameter int unsigned H_DISP   = LCD_H_DISP,
    parameter int unsigned H_FRONT  = LCD_H_FRONT,
    parameter int unsigned V_SYNC   = LCD_V_SYNC,
    parameter int unsigned V_BACK   = LCD_V_BACK,
    parameter int unsigned V_DISP   = LCD_V_DISP,
    parameter int unsigned V_FRONT  = LCD_V_FRONT,
    parameter bit          SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] pix_data_in,
    output logic              data_req,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_de,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BACK + V_DISP);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_act;
    logic             vs_act;
    logic             active;
    sync_flags_t      s0_flags;
    sync_flags_t      s1_flags;
    sync_flags_t      s2_flags;

    // Frame counters; disabling parks them at (0,0) so re-enable restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + CNT_W'(1);
            end
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Decode counter state; the request and coordinates go upstream with no added latency.
    always_comb begin
        hs_act     = (h_cnt < H_SYNC_END);
        vs_act     = (v_cnt < V_SYNC_END);
        active     = en
                     && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END)
                     && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        data_req   = active;
        pixel_xpos = active ? (h_cnt - H_ACT_BEG) : '0;
        pixel_ypos = active ? (v_cnt - V_ACT_BEG) : '0;
    end

    // Flags entering the output pipeline; all idle while disabled.
    always_comb begin
        s0_flags = '0;
        if (en) begin
            s0_flags.frame = (h_cnt == '0) && (v_cnt == '0);
            s0_flags.vs    = vs_act;
            s0_flags.hs    = hs_act;
            s0_flags.de    = active;
        end
    end

    // Stage 1: lines up with the upstream pixel returned one clock after data_req.
    vip_sync_delay #(
        .N (1)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flags_in  (s0_flags),
        .flags_out (s1_flags)
    );

    // Stage 2: final output flags.
    vip_sync_delay #(
        .N (1)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flags_in  (s1_flags),
        .flags_out (s2_flags)
    );

    // Output pixel register, gated to zero outside the active window so it aligns with out_de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else begin
            out_data <= s1_flags.de ? pix_data_in : '0;
        end
    end

    // Stage-2 flags to pins; syncs take the configured polarity, idle at the inactive level.
    always_comb begin
        out_hsync   = sync_level(s2_flags.hs, SYNC_POL);
        out_vsync   = sync_level(s2_flags.vs, SYNC_POL);
        out_de      = s2_flags.de;
        frame_start = s2_flags.frame;
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 10x6 timing; active-low and active-high
// instances run side by side on the same stimulus.
module tb_video_timing_gen;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] pix_data_in;

    logic          req0, vs0, hs0, de0, fs0;
    logic [10:0]   x0, y0;
    logic [DW-1:0] d0;
    logic          req1, vs1, hs1, de1, fs1;
    logic [10:0]   x1, y1;
    logic [DW-1:0] d1;

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
        .SYNC_POL(1'b0), .DATA_W(DW)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_data_in(pix_data_in),
        .data_req(req0), .pixel_xpos(x0), .pixel_ypos(y0),
        .out_vsync(vs0), .out_hsync(hs0), .out_de(de0), .out_data(d0),
        .frame_start(fs0)
    );

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
        .SYNC_POL(1'b1), .DATA_W(DW)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_data_in(pix_data_in),
        .data_req(req1), .pixel_xpos(x1), .pixel_ypos(y1),
        .out_vsync(vs1), .out_hsync(hs1), .out_de(de1), .out_data(d1),
        .frame_start(fs1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected output pixels, pushed when a request is issued.
    logic [DW-1:0] exp_q [$];
    bit            mon_on = 1'b0;

    // Monitor: on each output cycle, pop and compare while de is high, else expect zero data.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (mon_on) begin
            if (de0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_data: de high with no pixel expected, got %0h", d0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data_pol0", 32'(d0), 32'(e));
                    chk("out_data_pol1", 32'(d1), 32'(e));
                end
            end else begin
                chk("out_data_idle_pol0", 32'(d0), 0);
                chk("out_data_idle_pol1", 32'(d1), 0);
            end
        end
    end

    // Upstream source: returns {ypos, xpos} nibbles one clock after data_req, noise otherwise.
    initial begin
        logic          r;
        logic [DW-1:0] px;
        pix_data_in = 8'h00;
        forever begin
            @(negedge clk);
            r  = req0;
            px = {y0[3:0], x0[3:0]};
            @(posedge clk);
            #1;
            pix_data_in = r ? px : 8'hA5;
        end
    end

    // Bench timing model: local counters and expected flags of the two previous cycles.
    int         lh = 0;
    int         lv = 0;
    logic [3:0] hist0 = '0;   // {frame, de, vs, hs}
    logic [3:0] hist1 = '0;
    int         pc = 0;
    int         first_req = -1;
    int         de_cnt = 0;
    int         fs_q [$];

    // One clock with the given enable: check request side now, output side from 2 clocks ago.
    task automatic step(input logic en_v);
        logic       hs, vs, act, fs;
        logic [3:0] eo;
        en = en_v;
        @(negedge clk);
        hs  = en_v && (lh < 2);
        vs  = en_v && (lv < 1);
        act = en_v && (lh >= 4) && (lh < 8) && (lv >= 2) && (lv < 5);
        fs  = en_v && (lh == 0) && (lv == 0);
        chk("data_req", 32'(req0), 32'(act));
        chk("xpos", 32'(x0), act ? lh - 4 : 0);
        chk("ypos", 32'(y0), act ? lv - 2 : 0);
        chk("data_req_pol1", 32'(req1), 32'(act));
        chk("xpos_pol1", 32'(x1), act ? lh - 4 : 0);
        chk("ypos_pol1", 32'(y1), act ? lv - 2 : 0);
        if (act) exp_q.push_back(8'((lv - 2) * 16 + (lh - 4)));
        eo = hist1;
        chk("hsync_pol0", 32'(hs0), 32'(!eo[0]));
        chk("vsync_pol0", 32'(vs0), 32'(!eo[1]));
        chk("de_pol0", 32'(de0), 32'(eo[2]));
        chk("frame_start_pol0", 32'(fs0), 32'(eo[3]));
        chk("hsync_pol1", 32'(hs1), 32'(eo[0]));
        chk("vsync_pol1", 32'(vs1), 32'(eo[1]));
        chk("de_pol1", 32'(de1), 32'(eo[2]));
        chk("frame_start_pol1", 32'(fs1), 32'(eo[3]));
        if (fs0) fs_q.push_back(pc);
        if (req0 && first_req < 0) first_req = pc;
        if (de0 && pc >= 2 && pc < 62) de_cnt++;
        hist1 = hist0;
        hist0 = {fs, act, vs, hs};
        if (!en_v) begin
            lh = 0;
            lv = 0;
        end else if (lh == 9) begin
            lh = 0;
            lv = (lv == 5) ? 0 : lv + 1;
        end else begin
            lh++;
        end
        pc++;
        @(posedge clk);
        #1;
    endtask

    function automatic int fs_at(input int i);
        return (fs_q.size() > i) ? fs_q[i] : -1;
    endfunction

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_req", 32'(req0), 0);
        chk("rst_xpos", 32'(x0), 0);
        chk("rst_ypos", 32'(y0), 0);
        chk("rst_hsync_pol0", 32'(hs0), 1);
        chk("rst_vsync_pol0", 32'(vs0), 1);
        chk("rst_de", 32'(de0), 0);
        chk("rst_data", 32'(d0), 0);
        chk("rst_frame_start", 32'(fs0), 0);
        chk("rst_hsync_pol1", 32'(hs1), 0);
        chk("rst_vsync_pol1", 32'(vs1), 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (3) step(1'b0);

        // Two full frames plus a partial line.
        pc = 0; first_req = -1; de_cnt = 0; fs_q.delete();
        repeat (130) step(1'b1);
        chk("frame_start_first_cycle", fs_at(0), 2);
        chk("frame_start_second_cycle", fs_at(1), 62);
        chk("first_data_req_cycle", first_req, 24);
        chk("de_cycles_per_frame", de_cnt, 12);

        // Enable dropped mid row 1, re-enabled at cycle 50.
        repeat (5) step(1'b0);
        pc = 0; fs_q.delete();
        repeat (35) step(1'b1);
        repeat (15) step(1'b0);
        first_req = -1;
        repeat (80) step(1'b1);
        chk("abort_first_frame_start", fs_at(0), 2);
        chk("reenable_frame_start", fs_at(1), 52);
        chk("reenable_first_data_req", first_req, 74);

        // Asynchronous reset in the middle of an active pixel.
        repeat (5) step(1'b0);
        pc = 0;
        repeat (45) step(1'b1);
        chk("pre_reset_data_req", 32'(req0), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync", 32'(hs0), 1);
        chk("mid_rst_vsync", 32'(vs0), 1);
        chk("mid_rst_de", 32'(de0), 0);
        chk("mid_rst_data_req", 32'(req0), 0);
        chk("mid_rst_data", 32'(d0), 0);
        chk("mid_rst_hsync_pol1", 32'(hs1), 0);
        exp_q.delete();
        hist0 = '0; hist1 = '0; lh = 0; lv = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pc = 0; fs_q.delete();
        repeat (20) step(1'b1);
        chk("post_reset_frame_start", fs_at(0), 2);

        repeat (3) step(1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
